// File: rtl/bf16_pkg.sv
// bf16_pkg: bf16 field layout, widths and flat-bus operand slicing shared by the adder datapath
package bf16_pkg;
  localparam int BF16_W = 16;
  localparam int BF16_E_W = 8;
  localparam int BF16_M_W = 7;
  localparam int BF16_MAX_REQ = 16;
  localparam int BF16_BUS_W = BF16_MAX_REQ * BF16_W;
  typedef struct packed {
    logic s;
    logic [BF16_E_W-1:0] e;
    logic [BF16_M_W-1:0] m;
  } bf16_t;
  function automatic bf16_t bf16_slice(input logic [BF16_BUS_W-1:0] bus, input int unsigned i);
    return bus[BF16_W*i +: BF16_W];
  endfunction
endpackage

// File: rtl/bf16_add.sv
// bf16_add: combinational bf16 adder, round-to-nearest-even, subnormals flushed to zero
module bf16_add
  import bf16_pkg::*;
(
  input  logic [BF16_W-1:0] a,
  input  logic [BF16_W-1:0] b,
  output logic [BF16_W-1:0] sum
);
  bf16_t x, y, l, sm;
  logic x_ge, sub, inc, nan, zero_res;
  logic [7:0] sig_l, sig_s, d, rnd;
  logic [26:0] al;
  logic [10:0] ls, ss, n;
  logic [11:0] s12;
  logic [3:0] lz;
  logic [9:0] ex, ex_r;
  logic [15:0] fin;
  assign x = a;
  assign y = b;
  always_comb begin
    x_ge = {x.e, x.e == '0 ? 7'd0 : x.m} >= {y.e, y.e == '0 ? 7'd0 : y.m};
    l = x_ge ? x : y;
    sm = x_ge ? y : x;
    sig_l = (l.e == '0) ? 8'd0 : {1'b1, l.m};
    sig_s = (sm.e == '0) ? 8'd0 : {1'b1, sm.m};
    d = l.e - sm.e;
    // three extra bits below the lsb: guard, round, sticky
    al = {sig_s, 19'd0} >> d[4:0];
    ss = (d > 8'd19) ? {10'd0, |sig_s} : {al[26:17], |al[16:0]};
    ls = {sig_l, 3'd0};
    sub = l.s ^ sm.s;
    s12 = sub ? {1'b0, ls} - {1'b0, ss} : {1'b0, ls} + {1'b0, ss};
    lz = 4'd0;
    for (int i = 0; i < 11; i++) if (s12[i]) lz = 4'(10 - i);
    n = s12[11] ? {s12[11:2], |s12[1:0]} : s12[10:0] << lz;
    ex = {2'd0, l.e} + {9'd0, s12[11]} - {6'd0, s12[11] ? 4'd0 : lz};
    inc = n[2] & (n[1] | n[0] | n[3]);
    rnd = {1'b0, n[9:3]} + {7'd0, inc};
    ex_r = ex + {9'd0, rnd[7]};
    zero_res = !n[10];
    fin = zero_res ? {x.s & y.s, 15'd0}
        : (ex[9] || ex == '0) ? {l.s, 15'd0}
        : (ex_r >= 10'd255) ? {l.s, 8'hFF, 7'd0}
        : {l.s, ex_r[7:0], rnd[6:0]};
    nan = (x.e == 8'hFF && x.m != '0) || (y.e == 8'hFF && y.m != '0)
       || (x.e == 8'hFF && y.e == 8'hFF && x.s != y.s);
    sum = nan ? 16'h7FC0 : (x.e == 8'hFF) ? x : (y.e == 8'hFF) ? y : fin;
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting the search at ptr, one-hot and encoded outputs
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  localparam int SW = IW + 1;
  logic [SW-1:0] s;
  logic [IW-1:0] idx;
  always_comb begin
    gnt_idx = '0;
    any = 1'b0;
    s = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + SW'(k);
      idx = IW'(s >= SW'(N) ? s - SW'(N) : s);
      if (en && req[idx]) begin
        gnt_idx = idx;
        any = 1'b1;
      end
    end
    gnt = any ? {{(N-1){1'b0}}, 1'b1} << gnt_idx : '0;
  end
endmodule

// File: rtl/bf16_add_arb.sv
// bf16_add_arb: round-robin sharing of one bf16_add among N_REQ requesters with a registered tagged result
module bf16_add_arb
  import bf16_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*16-1:0]   req_a_i,
  input  logic [N_REQ*16-1:0]   req_b_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [15:0]           res_o,
  output logic [ID_W-1:0]       res_id_o
);
  logic [ID_W-1:0] ptr, gnt_idx;
  logic any;
  logic [BF16_BUS_W-1:0] a_bus, b_bus;
  bf16_t op_a, op_b;
  logic [BF16_W-1:0] sum;
  assign a_bus = BF16_BUS_W'(req_a_i);
  assign b_bus = BF16_BUS_W'(req_b_i);
  assign op_a = bf16_slice(a_bus, 32'(gnt_idx));
  assign op_b = bf16_slice(b_bus, 32'(gnt_idx));
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(req_valid_i),
    .ptr(ptr),
    .en((!res_valid_o || res_ready_i) && !rst),
    .gnt(req_ready_o),
    .gnt_idx(gnt_idx),
    .any(any)
  );
  bf16_add u_add (.a(op_a), .b(op_b), .sum(sum));
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_o <= 1'b0;
      res_o <= '0;
      res_id_o <= '0;
      ptr <= '0;
    end else if (any) begin
      res_valid_o <= 1'b1;
      res_o <= sum;
      res_id_o <= gnt_idx;
      ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bf16_add_arb.sv
// tb_bf16_add_arb: scoreboard bench, real-arithmetic bf16 reference and round-robin grant model
module tb_bf16_add_arb;
  localparam int N = 4;
  typedef struct {
    logic [15:0] res;
    logic [1:0] id;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid_i = '0;
  logic [N-1:0] req_ready_o;
  logic [N*16-1:0] req_a_i = '0;
  logic [N*16-1:0] req_b_i = '0;
  logic res_valid_o;
  logic res_ready_i = 1'b0;
  logic [15:0] res_o;
  logic [1:0] res_id_o;
  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  logic [N-1:0] v = '0;
  logic [15:0] ta[N];
  logic [15:0] tbv[N];
  int m_ptr = 0;
  bit m_full = 1'b0;

  bf16_add_arb #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .res_id_o(res_id_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    for (int i = 0; i < (e < 0 ? -e : e); i++) r = (e < 0) ? r / 2.0 : r * 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [15:0] x);
    if (x[14:7] == 8'd0) return 0.0;
    return (x[15] ? -1.0 : 1.0) * (1.0 + real'(x[6:0]) / 128.0) * pow2(int'(x[14:7]) - 127);
  endfunction

  // exact-enough: a double holds any sum of two bf16 values closely enough for one RNE step
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    real s, m, q, fl, fr;
    int e, f;
    bit neg;
    s = to_real(a) + to_real(b);
    if (s == 0.0) return {(to_real(a) == 0.0) && (to_real(b) == 0.0) && a[15] && b[15], 15'd0};
    neg = s < 0.0;
    m = neg ? -s : s;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    q = m * 128.0;
    fl = $floor(q);
    fr = q - fl;
    f = $rtoi(fl);
    if (fr > 0.5 || (fr == 0.5 && f % 2 == 1)) f++;
    if (f == 256) begin f = 128; e++; end
    if (e >= 255) return {neg, 8'hFF, 7'd0};
    if (e <= 0) return {neg, 15'd0};
    return {neg, 8'(e), 7'(f - 128)};
  endfunction

  function automatic logic [15:0] rnd_op();
    if ($urandom_range(0, 9) == 0) return {1'($urandom_range(0, 1)), 15'd0};
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 7'($urandom_range(0, 127))};
  endfunction

  task automatic step(input logic r, input logic rdy);
    int g;
    bit any;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst = r;
    res_ready_i = rdy;
    req_valid_i = v;
    for (int i = 0; i < N; i++) begin
      req_a_i[16*i +: 16] = ta[i];
      req_b_i[16*i +: 16] = tbv[i];
    end
    #1;
    any = 1'b0;
    g = 0;
    if (!r && (!m_full || rdy))
      for (int k = 0; k < N; k++)
        if (!any && v[(m_ptr + k) % N]) begin
          any = 1'b1;
          g = (m_ptr + k) % N;
        end
    exp_rdy = any ? N'(1) << g : '0;
    check("req_ready", 16'(req_ready_o), 16'(exp_rdy));
    check("res_valid", 16'(res_valid_o), 16'(m_full));
    if (r) begin
      m_full = 1'b0;
      m_ptr = 0;
      sb.delete();
    end else if (any) begin
      sb.push_back('{res: ref_add(ta[g], tbv[g]), id: 2'(g)});
      m_full = 1'b1;
      m_ptr = (g + 1) % N;
      v[g] = 1'b0;
    end else if (rdy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic arm(input int i, input logic [15:0] a, input logic [15:0] b);
    v[i] = 1'b1;
    ta[i] = a;
    tbv[i] = b;
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    #3;
    if (!rst && res_valid_o && res_ready_i) begin
      if (sb.size() == 0) check("orphan_result", 16'(sb.size()), 16'd1);
      else begin
        e = sb.pop_front();
        check("res", res_o, e.res);
        check("res_id", 16'(res_id_o), 16'(e.id));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) arm(i, 16'h3F80, 16'h3F00);
    step(1, 1);
    step(1, 1);
    for (int c = 0; c < 5; c++) begin
      step(0, 1);
      for (int i = 0; i < N; i++) arm(i, 16'h3F80, 16'h3F00);
    end
    v = '0;
    step(0, 1);
    arm(2, 16'h3F80, 16'h3F80);
    step(0, 1);
    step(0, 1);
    arm(1, 16'h4040, 16'hBF80);
    step(0, 1);
    arm(0, 16'h3F80, 16'h3C00);
    arm(3, 16'h4120, 16'hC000);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    arm(0, 16'h4000, 16'h4000);
    step(0, 1);
    arm(0, 16'h3F81, 16'h3B80);
    for (int c = 0; c < 5; c++) step(0, 0);
    step(0, 1);
    arm(0, 16'h8000, 16'h0000);
    step(0, 1);
    step(0, 1);
    arm(1, 16'h4200, 16'h4200);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    for (int i = 0; i < N; i++) arm(i, 16'h3F80, 16'h3F00);
    step(0, 1);
    v = '0;
    step(0, 1);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 99) < 50) arm(i, rnd_op(), rnd_op());
        else if (v[i] && $urandom_range(0, 99) < 3) v[i] = 1'b0;
      end
      step(0, $urandom_range(0, 3) != 0);
    end
    v = '0;
    for (int c = 0; c < 4; c++) step(0, 1);
    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
